fmul_seq: RTL and testbench
===========================

FMUL_SEQ -- requirements
Module: fmul_seq

Interface
REQ-001 SHALL have no parameters; the mantissa width of 24 and the exponent bias of 127 are fixed constants.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to multiply a by b; sampled only in IDLE.
REQ-005 SHALL have port a, input, 32 bits: IEEE-754 single-precision multiplicand, normal or zero.
REQ-006 SHALL have port b, input, 32 bits: IEEE-754 single-precision multiplier, normal or zero.
REQ-007 SHALL have port q, output, 32 bits: the product a*b, held stable until the next result.
REQ-008 SHALL have port ovf, output, 1 bit: set to 1 when q is infinity; held together with q.
REQ-009 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking that q and ovf have just been updated.

Function
REQ-011 SHALL implement the FSM states IDLE, MUL, NORM and DONE.
REQ-012 IDLE with start=1 SHALL capture a and b, clear the accumulator and bit counter, and go to MUL.
REQ-013 IDLE with start=0 SHALL hold all state.
REQ-014 MUL SHALL be a shift-add step over the 24-bit significands (hidden 1 included):
  - one multiplier bit per cycle, LSB first;
  - 48-bit product register;
  - exactly 24 cycles, then go to NORM.
REQ-015 NORM SHALL:
  - use exponent = ea + eb - 127;
  - if product bit 47 = 1, take mantissa from bits 46:24 and add 1 to the exponent; otherwise take bits 45:23;
  - apply rounding per REQ-024/025;
  - apply a rounding carry-out by renormalising and adding 1 to the exponent;
  - go to DONE.
REQ-016 DONE SHALL register q and ovf, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: if start is sampled at edge N, done is high in the cycle following edge N+26.
REQ-018 The earliest next start SHALL be sampled at edge N+27 (back-to-back issue allowed).
REQ-019 sign(q) SHALL equal sign(a) XOR sign(b) in every case, including zero and infinity results.
REQ-020 If either input exponent is 0, q SHALL be signed zero with ovf=0, after the full fixed latency.
REQ-021 If the final exponent is 255 or more, q SHALL be {sign, 8'hFF, 23'h0} and ovf SHALL be 1.
REQ-022 If the final exponent is 0 or less, q SHALL be signed zero with ovf=0 (no denormals).
REQ-023 start asserted while busy=1 SHALL be ignored; captured operands SHALL remain unchanged.

Configuration
REQ-024 With macro FMUL_SEQ_RNE_EN defined, NORM SHALL round to nearest-even using the guard bit and an OR-reduced sticky bit over all lower product bits.
REQ-025 With FMUL_SEQ_RNE_EN undefined, NORM SHALL truncate, the guard/sticky logic SHALL be absent, and latency SHALL be unchanged.

Reset
REQ-026 rstn=0 SHALL force IDLE, q=0, ovf=0, busy=0 and done=0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 After rstn deasserts, the block SHALL accept start at the first rising edge of clk.

Structure
REQ-029 A shared package fpu_pkg SHALL hold:
  - the state enum;
  - the constants BIAS=127, MANT_W=23 and EXP_MAX=255;
  - the infinity pattern.
REQ-030 The FSM, counter and shift-add datapath SHALL live in fmul_seq.
REQ-031 Rounding and normalisation SHALL live in one combinational sub-module, fmul_seq_round, reusable by other FPU blocks.

Verification
REQ-032 a=0x3FC00000, b=0x40000000, start at edge 0:
  - done high only in the cycle after edge 26;
  - q=0x40400000, ovf=0.
REQ-033 a=0x7F000000, b=0x40000000:
  - q=0x7F800000, ovf=1.
REQ-034 a=0xBF800000, b=0x40000000:
  - q=0xC0000000;
  - a=0x80000000, b=0x3F800000 gives q=0x80000000, ovf=0.
REQ-035 a=b=0x3FC00001:
  - q=0x40100002 with FMUL_SEQ_RNE_EN defined;
  - q=0x40100001 without it.
REQ-036 Pulse start again at cycles 5 and 10 of an operation:
  - pulses ignored, one done only, result matches the first operands;
  - a new start at edge 27 completes correctly.
REQ-037 Assert rstn=0 at cycle 12 of an operation:
  - q=0, busy=0, done=0 at once;
  - no done pulse afterwards;
  - the next operation gives the correct result.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: multiplier FSM states, IEEE-754 single-precision constants.
package fpu_pkg;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned EXP_MAX = 255;

    // Magnitude of infinity; the sign bit is prepended by the user.
    localparam logic [30:0] INF_MAG = {8'hFF, 23'h0};

endpackage

// File: rtl/fmul_seq_round.sv
// Combinational normalise/round/pack stage for a 24x24 significand product.
// Rounds to nearest-even when FMUL_SEQ_RNE_EN is defined, otherwise truncates.
module fmul_seq_round
    import fpu_pkg::*;
(
`ifdef FMUL_SEQ_RNE_EN
    input  logic [47:0] prod,
`else
    input  logic [47:23] prod,
`endif
    input  logic [7:0]  ea,
    input  logic [7:0]  eb,
    input  logic        sign,
    input  logic        zero,
    output logic [31:0] res,
    output logic        ovf
);

    localparam logic signed [10:0] ExpMaxS = 11'(EXP_MAX);

    logic signed [10:0]  exp_s;
    logic [MANT_W-1:0]   mant;
`ifdef FMUL_SEQ_RNE_EN
    logic                guard;
    logic                sticky;
    logic [MANT_W:0]     mant_r;
`endif

    always_comb begin
        // 11-bit signed headroom covers -125 .. 385 before range checks.
        exp_s = signed'(11'({3'b0, ea} + {3'b0, eb}) - 11'(BIAS));
        if (prod[47]) begin
            mant  = prod[46:24];
            exp_s = exp_s + 11'sd1;
        end else begin
            mant  = prod[45:23];
        end
`ifdef FMUL_SEQ_RNE_EN
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? |prod[22:0] : |prod[21:0];
        mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, guard & (sticky | mant[0])};
        // Carry-out leaves the fraction all-zero; only the exponent moves.
        if (mant_r[MANT_W]) begin
            exp_s = exp_s + 11'sd1;
        end
        mant = mant_r[MANT_W-1:0];
`endif
        res = {sign, 31'h0};
        ovf = 1'b0;
        if (!zero) begin
            if (exp_s >= ExpMaxS) begin
                res = {sign, INF_MAG};
                ovf = 1'b1;
            end else if (exp_s > 11'sd0) begin
                res = {sign, exp_s[7:0], mant};
            end
        end
    end

endmodule

// File: rtl/fmul_seq.sv
// Sequential single-precision multiplier: 24-cycle shift-add, then normalise and publish.
// Optional macro FMUL_SEQ_RNE_EN selects round-to-nearest-even instead of truncation.
module fmul_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [23:0] ma_q;
    logic [23:0] mb_q;
    logic [47:0] prod_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic        sign_q;
    logic        zero_q;
    logic [31:0] res_q;
    logic        rovf_q;
    logic [31:0] q_q;
    logic        ovf_q;
    logic        done_q;

    logic [24:0] sum;
    logic [31:0] rnd_res;
    logic        rnd_ovf;

    // Add into the upper half, then shift the whole product right one place.
    assign sum = {1'b0, prod_q[47:24]} + (mb_q[0] ? {1'b0, ma_q} : 25'd0);

    fmul_seq_round u_round (
`ifdef FMUL_SEQ_RNE_EN
        .prod (prod_q),
`else
        .prod (prod_q[47:23]),
`endif
        .ea   (ea_q),
        .eb   (eb_q),
        .sign (sign_q),
        .zero (zero_q),
        .res  (rnd_res),
        .ovf  (rnd_ovf)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMul;
            StMul:   if (cnt_q == 5'd23) state_d = StNorm;
            StNorm:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            prod_q <= '0;
            ea_q   <= '0;
            eb_q   <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            res_q  <= '0;
            rovf_q <= 1'b0;
            q_q    <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q  <= '0;
                        prod_q <= '0;
                        ma_q   <= {1'b1, a[22:0]};
                        mb_q   <= {1'b1, b[22:0]};
                        ea_q   <= a[30:23];
                        eb_q   <= b[30:23];
                        sign_q <= a[31] ^ b[31];
                        zero_q <= (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
                    end
                end
                StMul: begin
                    prod_q <= {sum, prod_q[23:1]};
                    mb_q   <= {1'b0, mb_q[23:1]};
                    cnt_q  <= cnt_q + 5'd1;
                end
                StNorm: begin
                    res_q  <= rnd_res;
                    rovf_q <= rnd_ovf;
                end
                StDone: begin
                    q_q   <= res_q;
                    ovf_q <= rovf_q;
                end
                default: ;
            endcase
        end
    end

    assign q    = q_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Directed self-checking bench for fmul_seq: results, fixed latency, ignored starts, reset abort.
module tb_fmul_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fmul_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .a    (a),
        .b    (b),
        .q    (q),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Entered #1 after a rising edge; start is sampled at the next edge (edge N).
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_q, input logic exp_ovf, input bit inject);
        int lat;
        lat   = 0;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_done_low"}, {31'b0, done}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (inject && (k == 5 || k == 10)) begin
                start = 1'b1;
                a     = 32'h7F000000;
                b     = 32'h7F000000;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) lat = k;
        end
        check({tag, "_latency"}, 32'(lat), 32'd26);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
        check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        rstn  = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        check("rst_q", q, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
        run_op("neg", 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0);
        run_op("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0);
`ifdef FMUL_SEQ_RNE_EN
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 1'b0, 1'b0);
`else
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 1'b0, 1'b0);
`endif
        run_op("max_sig", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0);
        run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b0);
        run_op("neg_inf", 32'hFF000000, 32'h40000000, 32'hFF800000, 1'b1, 1'b0);
        run_op("neg_neg", 32'hC0000000, 32'hC0000000, 32'h40800000, 1'b0, 1'b0);

        // Spurious starts mid-operation, then an immediate back-to-back issue.
        run_op("ignore", 32'h3F800000, 32'h40400000, 32'h40400000, 1'b0, 1'b1);
        run_op("b2b", 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse_end", {31'b0, done}, 32'd0);

        // Abort an operation with reset at cycle 12.
        a     = 32'h3FC00000;
        b     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
        end
        #1;
        rstn = 1'b0;
        #1;
        check("abort_q", q, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
